data_ram_responder: RTL and testbench

//  Responder end of the CPU data-memory port driven by datapath (ram_ce/we/sel/addr).

---
 rtl/mem_pkg.sv | 31 +++
 rtl/sp_bram_be.sv | 27 ++
 rtl/data_ram_responder.sv | 108 ++++++++++
 tb/tb_data_ram_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared lane constants, store-buffer entry type and lane merge helper
package mem_pkg;

  localparam int BYTE_LANES = 4;
  // Wide enough for any word index of a 32-bit byte address space.
  localparam int IDX_W = 30;

  localparam logic [3:0] SEL_NONE    = 4'b0000;
  localparam logic [3:0] SEL_WORD    = 4'b1111;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [BYTE_LANES-1:0][3:0] SEL_BYTE = {4'b1000, 4'b0100, 4'b0010, 4'b0001};

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [3:0]       sel;
    logic [31:0]      data;
  } store_buf_t;

  function automatic logic [31:0] lane_merge(input logic [31:0] base,
                                             input logic [31:0] over,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = base;
    for (int k = 0; k < BYTE_LANES; k++) begin
      if ((sel & SEL_BYTE[k]) != SEL_NONE) r[8*k +: 8] = over[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sp_bram_be.sv
// rtl/sp_bram_be.sv - single-port byte-write-enable word array with registered read
module sp_bram_be #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  // Read-first; contents are never reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - CPU data-port responder: range decode, posted store buffer, forwarding
module data_ram_responder
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ram_ce_i,
  input  logic        ram_we_i,
  input  logic [3:0]  ram_sel_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_wdata_i,
  output logic [31:0] ram_rdata_o,
  output logic        ram_valid_o,
  output logic        addr_err_o
);

  localparam int AW = $clog2(DEPTH);

  // 33-bit offset: an address below BASE_ADDR wraps to a huge value and fails the bound.
  logic [32:0]   rel;
  logic          in_range;
  logic [AW-1:0] idx;

  assign rel      = {1'b0, ram_addr_i} - {1'b0, BASE_ADDR};
  assign in_range = rel < 33'(4 * DEPTH);
  assign idx      = AW'(rel >> 2);

  logic req_load, req_store, req_err, commit;

  assign req_load  = ram_ce_i & ~ram_we_i & in_range;
  assign req_store = ram_ce_i &  ram_we_i & in_range & (ram_sel_i != SEL_NONE);
  assign req_err   = ram_ce_i & ~in_range;

  store_buf_t sb;
  logic       sb_v;
  logic       sb_hit;

  // Loads own the array port; a pending store drains on any other cycle.
  assign commit = sb_v & ~req_load;
  assign sb_hit = sb_v && (sb.idx == IDX_W'(idx));

  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_rdata;

  assign bram_en   = ~rst_i & (req_load | commit);
  assign bram_we   = (~rst_i & commit) ? sb.sel : SEL_NONE;
  assign bram_addr = req_load ? idx : sb.idx[AW-1:0];

  sp_bram_be #(.AW(AW)) u_array (
    .clk   (clk_i),
    .en    (bram_en),
    .we    (bram_we),
    .addr  (bram_addr),
    .wdata (sb.data),
    .rdata (bram_rdata)
  );

  logic        load_q;
  logic        err_q;
  logic [3:0]  fwd_sel_q;
  logic [31:0] fwd_data_q;
  logic [31:0] rdata_hold;
  logic [31:0] merged;

  // Forwarding lanes are captured at load time since the buffer may drain the next cycle.
  assign merged      = lane_merge(bram_rdata, fwd_data_q, fwd_sel_q);
  assign ram_rdata_o = load_q ? merged : rdata_hold;
  assign ram_valid_o = load_q;
  assign addr_err_o  = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_v       <= 1'b0;
      sb         <= '0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
      fwd_sel_q  <= SEL_NONE;
      fwd_data_q <= '0;
      rdata_hold <= '0;
    end else begin
      load_q <= req_load;
      err_q  <= req_err;

      if (load_q)  rdata_hold <= merged;
      if (req_err) rdata_hold <= '0;

      if (req_load) begin
        fwd_sel_q  <= sb_hit ? sb.sel : SEL_NONE;
        fwd_data_q <= sb.data;
      end

      if (req_store) begin
        sb.idx  <= IDX_W'(idx);
        sb.sel  <= ram_sel_i;
        sb.data <= ram_wdata_i;
        sb_v    <= 1'b1;
      end else if (commit) begin
        sb_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// tb/tb_data_ram_responder.sv - directed and randomized self-check of data_ram_responder
module tb_data_ram_responder;
  import mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;
  localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        valid, aerr;

  always #5 clk = ~clk;

  data_ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .ram_ce_i(ce), .ram_we_i(we), .ram_sel_i(sel),
    .ram_addr_i(addr), .ram_wdata_i(wdata), .ram_rdata_o(rdata),
    .ram_valid_o(valid), .addr_err_o(aerr)
  );

  // Reference: committed memory plus at most one posted-but-uncommitted store.
  logic [31:0] m_mem [DEPTH];
  logic        p_v = 1'b0;
  int          p_idx;
  logic [3:0]  p_sel;
  logic [31:0] p_data;
  logic        e_valid, e_err;
  logic [31:0] e_rdata;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] overlay(input logic [31:0] w, input logic [31:0] d,
                                          input logic [3:0] s);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] visible(input int i);
    if (p_v && p_idx == i) return overlay(m_mem[i], p_data, p_sel);
    return m_mem[i];
  endfunction

  function automatic logic [31:0] wa(input int i);
    return BASE + 32'(4 * i);
  endfunction

  task automatic drain();
    if (p_v) m_mem[p_idx] = overlay(m_mem[p_idx], p_data, p_sel);
    p_v = 1'b0;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One request cycle: drive, advance the model, clock, then compare all outputs.
  task automatic step(input logic r, input logic c, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d);
    longint off;
    int     i;
    bit     inr;
    rst = r; ce = c; we = w; sel = s; addr = a; wdata = d;
    off = longint'(a) - longint'(BASE);
    inr = (off >= 0) && (off < 4 * DEPTH);
    i   = int'(off / 4);
    if (r) begin
      p_v = 1'b0; e_valid = 1'b0; e_err = 1'b0; e_rdata = '0;
    end else if (c && !inr) begin
      drain(); e_valid = 1'b0; e_err = 1'b1; e_rdata = '0;
    end else if (c && !w) begin
      e_valid = 1'b1; e_err = 1'b0; e_rdata = visible(i);
    end else if (c && w && s != 4'b0) begin
      drain(); p_v = 1'b1; p_idx = i; p_sel = s; p_data = d;
      e_valid = 1'b0; e_err = 1'b0;
    end else begin
      drain(); e_valid = 1'b0; e_err = 1'b0;
    end
    @(posedge clk);
    #1;
    chk1("valid", valid, e_valid);
    chk1("addr_err", aerr, e_err);
    chk32("rdata", rdata, e_rdata);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'b0, '0, '0);
  endtask

  logic [31:0] old_v;

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 4'b0, '0, '0);
    step(1'b1, 1'b1, 1'b1, SEL_WORD, wa(1), 32'h1234_5678);
    chk1("reset_valid", valid, 1'b0);
    chk1("reset_err", aerr, 1'b0);
    chk32("reset_rdata", rdata, 32'h0);

    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, SEL_WORD, wa(i), $urandom);
    idle();

    // 1: full-word store then load
    step(1'b0, 1'b1, 1'b1, SEL_WORD, wa(5), 32'hDEAD_BEEF);
    idle();
    step(1'b0, 1'b1, 1'b0, SEL_HALF_LO, wa(5), '0);
    chk32("t1_rdata", rdata, 32'hDEAD_BEEF);
    chk1("t1_valid", valid, 1'b1);

    // 2: byte merge through the buffer, then from the array
    step(1'b0, 1'b1, 1'b1, SEL_WORD, wa(7), 32'h1122_3344);
    step(1'b0, 1'b1, 1'b1, SEL_BYTE[1], wa(7), 32'h0000_AA00);
    step(1'b0, 1'b1, 1'b0, SEL_WORD, wa(7), '0);
    chk32("t2_fwd", rdata, 32'h1122_AA44);
    idle();
    step(1'b0, 1'b1, 1'b0, SEL_WORD, wa(7), '0);
    chk32("t2_array", rdata, 32'h1122_AA44);

    // 3: back-to-back loads keep the store pending; reset then discards it
    step(1'b0, 1'b1, 1'b1, SEL_WORD, wa(3), 32'hCAFE_F00D);
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 1'b1, 1'b0, SEL_WORD, wa(3), '0);
      chk32("t3_load", rdata, 32'hCAFE_F00D);
    end
    idle();
    step(1'b0, 1'b1, 1'b1, SEL_HALF_HI, wa(3), 32'h1234_0000);
    for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 1'b0, SEL_WORD, wa(3), '0);
    step(1'b1, 1'b0, 1'b0, 4'b0, '0, '0);
    idle();
    step(1'b0, 1'b1, 1'b0, SEL_WORD, wa(3), '0);
    chk32("t3_committed", rdata, 32'hCAFE_F00D);

    // 4: just past the top and just below the base
    step(1'b0, 1'b1, 1'b0, SEL_WORD, TOP, '0);
    chk1("t4_err", aerr, 1'b1);
    chk32("t4_rdata", rdata, 32'h0);
    step(1'b0, 1'b1, 1'b1, SEL_WORD, BASE - 32'd4, 32'hFFFF_FFFF);
    chk1("t4_err_low", aerr, 1'b1);
    step(1'b0, 1'b1, 1'b0, SEL_WORD, wa(DEPTH - 1), '0);
    chk1("t4_top_word_ok", aerr, 1'b0);

    // 5: reset drops an uncommitted store
    old_v = visible(9);
    step(1'b0, 1'b1, 1'b1, SEL_WORD, wa(9), 32'h5555_5555);
    step(1'b1, 1'b0, 1'b0, 4'b0, '0, '0);
    chk32("t5_rst_rdata", rdata, 32'h0);
    idle();
    step(1'b0, 1'b1, 1'b0, SEL_WORD, wa(9), '0);
    chk32("t5_old", rdata, old_v);

    // 6: empty lane mask is a no-op
    old_v = visible(2);
    step(1'b0, 1'b1, 1'b1, SEL_NONE, wa(2), 32'hFFFF_FFFF);
    chk1("t6_noerr", aerr, 1'b0);
    step(1'b0, 1'b1, 1'b0, SEL_WORD, wa(2), '0);
    chk32("t6_old", rdata, old_v);

    for (int n = 0; n < 400; n++) begin
      int unsigned pick;
      logic [31:0] a;
      pick = $urandom_range(0, 99);
      a = wa(int'($urandom_range(0, 7))) + 32'($urandom_range(0, 3));
      if (pick < 4)       step(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), a, $urandom);
      else if (pick < 15) idle();
      else if (pick < 22) step(1'b0, 1'b1, 1'($urandom),
                               4'($urandom), (pick & 1) ? TOP + 32'($urandom_range(0, 64)) : BASE - 32'($urandom_range(1, 64)),
                               $urandom);
      else if (pick < 60) step(1'b0, 1'b1, 1'b1, 4'($urandom), a, $urandom);
      else                step(1'b0, 1'b1, 1'b0, 4'($urandom), a, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
